serv_wb_bridge: RTL and testbench

//  Merges the SERV core's separate ibus (fetch) and dbus (load/store) masters onto the single

---
 rtl/serv_wb_bridge.sv | 198 +++++++++++++++++++
 tb/tb_serv_wb_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_wb_bridge.sv
// Joins the SERV ibus and dbus masters onto one Wishbone port (no byte select).
// Arbitrates with dbus priority and turns sub-word stores into read-merge-write.
module serv_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_core_cyc,
  output logic        o_core_stb,
  output logic        o_core_we,
  output logic [31:0] o_core_addr,
  output logic [31:0] o_core_data,
  input  logic [31:0] i_core_data,
  input  logic        i_core_ack,
  output logic        o_timeout
);

  localparam int unsigned   CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit            TMO_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_IBUS, S_DRD, S_DWR, S_RMW_RD, S_RMW_MRG, S_RMW_WR, S_DONE
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic             r_cyc,      w_cyc_nxt;
  logic             r_we,       w_we_nxt;
  logic [31:0]      r_addr,     w_addr_nxt;
  logic [31:0]      r_wdat,     w_wdat_nxt;
  logic [3:0]       r_sel,      w_sel_nxt;
  logic [31:0]      r_ibus_rdt, w_ibus_rdt_nxt;
  logic [31:0]      r_dbus_rdt, w_dbus_rdt_nxt;
  logic             r_ibus_ack, w_ibus_ack_nxt;
  logic             r_dbus_ack, w_dbus_ack_nxt;
  logic             r_timeout,  w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_expired;
  logic [31:0]      w_mask;
  logic [31:0]      w_merged;
  logic             w_unused;

  // Word addressing discards the byte offset bits
  assign w_unused  = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

  assign w_mask    = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_merged  = (i_core_data & ~w_mask) | (r_wdat & w_mask);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_expired = TMO_EN && r_cyc && !i_core_ack && (w_cnt_inc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdat     <= '0;
      r_sel      <= '0;
      r_ibus_rdt <= '0;
      r_dbus_rdt <= '0;
      r_ibus_ack <= 1'b0;
      r_dbus_ack <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc      <= w_cyc_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdat     <= w_wdat_nxt;
      r_sel      <= w_sel_nxt;
      r_ibus_rdt <= w_ibus_rdt_nxt;
      r_dbus_rdt <= w_dbus_rdt_nxt;
      r_ibus_ack <= w_ibus_ack_nxt;
      r_dbus_ack <= w_dbus_ack_nxt;
      r_timeout  <= w_timeout_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cyc_nxt      = r_cyc;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdat_nxt     = r_wdat;
    w_sel_nxt      = r_sel;
    w_ibus_rdt_nxt = r_ibus_rdt;
    w_dbus_rdt_nxt = r_dbus_rdt;
    w_ibus_ack_nxt = 1'b0;
    w_dbus_ack_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_cnt_nxt      = r_cnt;
    if (r_cyc && TMO_EN) w_cnt_nxt = w_cnt_inc;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_dbus_cyc) begin
          w_addr_nxt = {i_dbus_adr[31:2], 2'b00};
          w_wdat_nxt = i_dbus_dat;
          w_sel_nxt  = i_dbus_sel;
          if (!i_dbus_we) begin
            w_state_nxt = S_DRD;
            w_cyc_nxt   = 1'b1;
            w_we_nxt    = 1'b0;
          end else if (i_dbus_sel == 4'hF) begin
            w_state_nxt = S_DWR;
            w_cyc_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
          end else if (i_dbus_sel == 4'h0) begin
            w_state_nxt    = S_DONE;
            w_dbus_ack_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RMW_RD;
            w_cyc_nxt   = 1'b1;
            w_we_nxt    = 1'b0;
          end
        end else if (i_ibus_cyc) begin
          w_addr_nxt  = {i_ibus_adr[31:2], 2'b00};
          w_state_nxt = S_IBUS;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
        end
      end
      S_IBUS: if (i_core_ack) begin
        w_cyc_nxt      = 1'b0;
        w_ibus_rdt_nxt = i_core_data;
        w_ibus_ack_nxt = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_DRD: if (i_core_ack) begin
        w_cyc_nxt      = 1'b0;
        w_dbus_rdt_nxt = i_core_data;
        w_dbus_ack_nxt = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_DWR, S_RMW_WR: if (i_core_ack) begin
        w_cyc_nxt      = 1'b0;
        w_dbus_ack_nxt = 1'b1;
        w_state_nxt    = S_DONE;
      end
      S_RMW_RD: if (i_core_ack) begin
        w_cyc_nxt   = 1'b0;
        w_wdat_nxt  = w_merged;
        w_state_nxt = S_RMW_MRG;
      end
      S_RMW_MRG: begin
        w_cnt_nxt   = '0;
        w_cyc_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_state_nxt = S_RMW_WR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort: the owning master still gets its ack, carrying ERR_DATA
    if (w_expired) begin
      w_cyc_nxt     = 1'b0;
      w_timeout_nxt = 1'b1;
      w_state_nxt   = S_DONE;
      if (r_state == S_IBUS) begin
        w_ibus_rdt_nxt = ERR_DATA;
        w_ibus_ack_nxt = 1'b1;
      end else begin
        w_dbus_rdt_nxt = ERR_DATA;
        w_dbus_ack_nxt = 1'b1;
      end
    end
  end

  assign o_core_cyc  = r_cyc;
  assign o_core_stb  = r_cyc;
  assign o_core_we   = r_we;
  assign o_core_addr = r_addr;
  assign o_core_data = r_wdat;
  assign o_ibus_rdt  = r_ibus_rdt;
  assign o_ibus_ack  = r_ibus_ack;
  assign o_dbus_rdt  = r_dbus_rdt;
  assign o_dbus_ack  = r_dbus_ack;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_serv_wb_bridge.sv
// Randomized bench for serv_wb_bridge: a Wishbone memory responder plus a
// transaction-level reference of memory contents, returned data and latency.
module tb_serv_wb_bridge;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat;
  logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_core_addr, o_core_data, i_core_data;
  logic        o_ibus_ack, o_dbus_ack, o_core_cyc, o_core_stb, o_core_we, i_core_ack, o_timeout;

  always #5 clk = ~clk;

  serv_wb_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_core_cyc(o_core_cyc), .o_core_stb(o_core_stb), .o_core_we(o_core_we),
    .o_core_addr(o_core_addr), .o_core_data(o_core_data),
    .i_core_data(i_core_data), .i_core_ack(i_core_ack), .o_timeout(o_timeout)
  );

  // Memory responder: 256 words aliased over the address space
  bit   [31:0] mem [256];
  bit          mem_wr [256];
  int          mem_lat = 0;
  bit          mem_hang = 1'b0;
  logic        spur;
  int          wait_cnt;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] last_addr;
  int          n_rd = 0, n_wr = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_get(input logic [7:0] idx);
    return mem_wr[idx] ? mem[idx] : init_word(int'(idx));
  endfunction

  assign i_core_ack  = mem_ack | spur;
  assign i_core_data = mem_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_ack) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (o_core_cyc && !mem_hang) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack   <= 1'b1;
        last_addr <= o_core_addr;
        if (o_core_we) begin
          mem[o_core_addr[9:2]]    <= o_core_data;
          mem_wr[o_core_addr[9:2]] <= 1'b1;
          n_wr <= n_wr + 1;
        end else begin
          mem_rdata <= mem_get(o_core_addr[9:2]);
          n_rd <= n_rd + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  int n_iack = 0, n_dack = 0, n_tmo = 0;
  always @(posedge clk) begin
    if (o_ibus_ack) n_iack <= n_iack + 1;
    if (o_dbus_ack) n_dack <= n_dack + 1;
    if (o_timeout)  n_tmo  <= n_tmo + 1;
  end

  // Reference model of memory and of the last data returned to each master
  bit   [31:0] ref_mem [256];
  bit          ref_wr [256];
  logic [31:0] exp_irdt = '0, exp_drdt = '0;

  function automatic logic [31:0] ref_get(input logic [7:0] idx);
    return ref_wr[idx] ? ref_mem[idx] : init_word(int'(idx));
  endfunction

  int n_pass = 0, n_chk = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic run_txn(input int kind, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    logic [7:0]  idx;
    logic [31:0] old, bmask;
    int n_acc, e_rd, e_wr, e_lat, e_tmo, lat, cyc_hi, i0, d0, t0, r0, w0;
    bit acked;
    idx = adr[9:2];
    old = ref_get(idx);
    bmask = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) bmask[8*b +: 8] = 8'hFF;
    check_eq("ibus_rdt_hold", o_ibus_rdt, exp_irdt);
    check_eq("dbus_rdt_hold", o_dbus_rdt, exp_drdt);

    e_rd  = (kind != 2 || (sel != 4'hF && sel != 4'h0)) ? 1 : 0;
    e_wr  = (kind == 2 && sel != 4'h0) ? 1 : 0;
    n_acc = e_rd + e_wr;
    if (mem_hang && n_acc > 0) begin
      e_tmo = 1; e_lat = TMO + 1; e_rd = 0; e_wr = 0;
    end else begin
      e_tmo = 0; e_lat = n_acc * (mem_lat + 2) + 1 + ((n_acc == 2) ? 1 : 0);
    end
    if (kind == 0)      exp_irdt = e_tmo ? ERR : old;
    else if (kind == 1) exp_drdt = e_tmo ? ERR : old;
    else if (e_tmo)     exp_drdt = ERR;
    else begin
      ref_mem[idx] = (old & ~bmask) | (dat & bmask);
      ref_wr[idx]  = 1'b1;
    end

    i0 = n_iack; d0 = n_dack; t0 = n_tmo; r0 = n_rd; w0 = n_wr;
    if (kind == 0) begin
      i_ibus_adr = adr; i_ibus_cyc = 1'b1;
    end else begin
      i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = sel;
      i_dbus_we = (kind == 2); i_dbus_cyc = 1'b1;
    end
    lat = 0; cyc_hi = 0; acked = 1'b0;
    for (int c = 0; c < 200 && !acked; c++) begin
      @(posedge clk); #1;
      lat++;
      if (o_core_cyc) cyc_hi++;
      acked = (kind == 0) ? o_ibus_ack : o_dbus_ack;
    end
    check_eq("ack_seen", 32'(acked), 32'd1);
    check_eq("latency", 32'(lat), 32'(e_lat));
    if (kind == 0)      check_eq("ibus_rdata", o_ibus_rdt, exp_irdt);
    else if (kind == 1) check_eq("dbus_rdata", o_dbus_rdt, exp_drdt);
    else if (e_tmo == 1) check_eq("store_err_rdt", o_dbus_rdt, ERR);
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    @(posedge clk); #1;
    check_eq("own_ack_pulses", 32'((kind == 0) ? n_iack - i0 : n_dack - d0), 32'd1);
    check_eq("other_ack_pulses", 32'((kind == 0) ? n_dack - d0 : n_iack - i0), 32'd0);
    check_eq("timeout_pulses", 32'(n_tmo - t0), 32'(e_tmo));
    check_eq("bus_reads", 32'(n_rd - r0), 32'(e_rd));
    check_eq("bus_writes", 32'(n_wr - w0), 32'(e_wr));
    check_eq("idle_cyc", 32'({o_core_cyc, o_core_stb}), 32'd0);
    if (e_rd + e_wr > 0) check_eq("word_addr", last_addr, {adr[31:2], 2'b00});
    if (e_tmo == 1) check_eq("cyc_high_cycles", 32'(cyc_hi), 32'(TMO));
    check_eq("mem_word", mem_get(idx), ref_get(idx));
  endtask

  // Fetch and load raised together: dbus first, then ibus after DONE
  task automatic run_both(input logic [31:0] ia, input logic [31:0] da);
    int lat, i_at, d_at, i0, d0;
    bit got_i, got_d;
    logic [31:0] i_rdt, d_rdt;
    i0 = n_iack; d0 = n_dack;
    i_ibus_adr = ia; i_ibus_cyc = 1'b1;
    i_dbus_adr = da; i_dbus_we = 1'b0; i_dbus_sel = 4'h1; i_dbus_cyc = 1'b1;
    lat = 0; i_at = 0; d_at = 0; got_i = 1'b0; got_d = 1'b0; i_rdt = '0; d_rdt = '0;
    for (int c = 0; c < 200 && !(got_i && got_d); c++) begin
      @(posedge clk); #1;
      lat++;
      if (o_dbus_ack && !got_d) begin got_d = 1'b1; d_at = lat; d_rdt = o_dbus_rdt; i_dbus_cyc = 1'b0; end
      if (o_ibus_ack && !got_i) begin got_i = 1'b1; i_at = lat; i_rdt = o_ibus_rdt; i_ibus_cyc = 1'b0; end
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    exp_irdt = ref_get(ia[9:2]);
    exp_drdt = ref_get(da[9:2]);
    check_eq("both_dbus_lat", 32'(d_at), 32'(mem_lat + 3));
    check_eq("both_ibus_lat", 32'(i_at), 32'(2 * mem_lat + 7));
    check_eq("both_dbus_rdt", d_rdt, exp_drdt);
    check_eq("both_ibus_rdt", i_rdt, exp_irdt);
    @(posedge clk); #1;
    check_eq("both_iack_pulses", 32'(n_iack - i0), 32'd1);
    check_eq("both_dack_pulses", 32'(n_dack - d0), 32'd1);
  endtask

  // Reset lands during the write phase of a sub-word store
  task automatic run_reset_rmw(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] old, merged;
    int lat, d0, r0, w0;
    bit seen, acked;
    old    = ref_get(adr[9:2]);
    merged = {old[31:24], dat[23:8], old[7:0]};
    d0 = n_dack; w0 = n_wr;
    i_dbus_adr = adr; i_dbus_dat = dat; i_dbus_sel = 4'b0110; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      seen = o_core_cyc && o_core_we;
    end
    check_eq("rst_reached_write", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_cyc", 32'({o_core_cyc, o_core_stb}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_ack", 32'(n_dack - d0), 32'd0);
    check_eq("rst_no_write", 32'(n_wr - w0), 32'd0);
    check_eq("rst_rdt_clear", o_dbus_rdt, 32'd0);
    rst_n = 1'b1;
    exp_irdt = '0; exp_drdt = '0;
    r0 = n_rd; w0 = n_wr;
    lat = 0; acked = 1'b0;
    for (int c = 0; c < 200 && !acked; c++) begin
      @(posedge clk); #1;
      lat++;
      acked = o_dbus_ack;
    end
    i_dbus_cyc = 1'b0;
    check_eq("rst_restart_lat", 32'(lat), 32'(2 * mem_lat + 6));
    @(posedge clk); #1;
    check_eq("rst_restart_reads", 32'(n_rd - r0), 32'd1);
    check_eq("rst_restart_writes", 32'(n_wr - w0), 32'd1);
    check_eq("rst_total_acks", 32'(n_dack - d0), 32'd1);
    check_eq("rst_merged_word", mem_get(adr[9:2]), merged);
    ref_mem[adr[9:2]] = merged;
    ref_wr[adr[9:2]]  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0, d0, kind;
    logic [3:0] sel;
    rst_n = 1'b0; spur = 1'b0;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cyc_stb_we", 32'({o_core_cyc, o_core_stb, o_core_we}), 32'd0);
    check_eq("rst_addr", o_core_addr, 32'd0);
    check_eq("rst_wdata", o_core_data, 32'd0);
    check_eq("rst_ibus_rdt", o_ibus_rdt, 32'd0);
    check_eq("rst_dbus_rdt", o_dbus_rdt, 32'd0);
    check_eq("rst_acks_tmo", 32'({o_ibus_ack, o_dbus_ack, o_timeout}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mem_lat = 0;
    run_txn(2, 32'h0000_0104, 32'h0000_0013, 4'hF);
    run_txn(0, 32'h0000_0104, 32'h0, 4'h0);
    check_eq("fetch_0x104", o_ibus_rdt, 32'h0000_0013);
    run_txn(2, 32'h0000_0100, 32'h1122_3344, 4'hF);
    run_txn(2, 32'h0000_0103, 32'hAA00_0000, 4'b1000);
    check_eq("sb_merge", mem_get(8'h40), 32'hAA22_3344);
    run_txn(2, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
    check_eq("sw_word", mem_get(8'h80), 32'hDEAD_BEEF);
    run_txn(2, 32'h0000_0300, 32'h5555_5555, 4'h0);
    run_txn(1, 32'h0000_0102, 32'h0, 4'b0100);

    mem_lat = 1;
    run_both(32'h0000_0104, 32'h0000_0200);

    i0 = n_iack; d0 = n_dack;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check_eq("spur_no_cyc", 32'(o_core_cyc), 32'd0);
    @(posedge clk); #1;
    check_eq("spur_no_ack", 32'((n_iack - i0) + (n_dack - d0)), 32'd0);

    mem_hang = 1'b1;
    run_txn(0, 32'h0000_0040, 32'h0, 4'h0);
    run_txn(2, 32'h0000_0044, 32'h0102_0304, 4'b0011);
    run_txn(2, 32'h0000_0048, 32'h0102_0304, 4'hF);
    mem_hang = 1'b0;

    mem_lat = 6;
    run_reset_rmw(32'h0000_0124, 32'hCAFE_F00D);

    for (int n = 0; n < 150; n++) begin
      mem_lat  = $urandom_range(0, 3);
      mem_hang = ($urandom_range(0, 15) == 0);
      kind     = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       sel = 4'hF;
        1:       sel = 4'h0;
        default: sel = 4'($urandom());
      endcase
      run_txn(kind, $urandom(), $urandom(), sel);
    end
    mem_hang = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
